// File: rtl/paula_audio_mixer_mc.sv
// paula_audio_mixer_mc: time-multiplexed NCH-channel Paula stereo mixer.
// One shared multiplier scales one channel per clk. The left and right sums
// build up in two accumulators, and a registered stereo pair is presented
// with a one-cycle out_valid strobe.
// Optional build macro PAULA_MIX_SAT_EN: when OUT_W < ACC_W the outputs
// saturate to the signed OUT_W range. Without the macro they keep the low
// OUT_W bits of the accumulator and therefore wrap.
//
// state | meaning
// IDLE  | waiting for mix_stb & clk7_en; shadows hold the last accepted inputs
// RUN   | scaling/accumulating channel idx, one channel per clk
// DONE  | loading output registers and raising out_valid
module paula_audio_mixer_mc #(
  parameter int NCH = 4,
  parameter int SW = 8,
  parameter int OUT_W = 15,
  parameter logic [NCH-1:0] LEFT_MASK = NCH'(4'b0110)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk7_en,
  input  logic                    mix_stb,
  input  logic                    mono,
  input  logic [NCH*SW-1:0]       sample,
  input  logic [NCH*7-1:0]        vol,
  output logic signed [OUT_W-1:0] ldatasum,
  output logic signed [OUT_W-1:0] rdatasum,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IDXW  = $clog2(NCH);
  localparam int PW    = SW + 7;
  localparam int ACC_W = SW + 7 + $clog2(NCH);
  localparam int WIDE  = (OUT_W > ACC_W) ? OUT_W : ACC_W;

`ifdef PAULA_MIX_SAT_EN
  localparam logic signed [WIDE-1:0] SAT_MAX = WIDE'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [WIDE-1:0] SAT_MIN = -SAT_MAX - 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [NCH*SW-1:0]        samp_q, samp_d;
  logic [NCH*7-1:0]         vol_q, vol_d;
  logic                     mono_q, mono_d;
  logic signed [ACC_W-1:0]  lacc_q, lacc_d;
  logic signed [ACC_W-1:0]  racc_q, racc_d;
  logic signed [OUT_W-1:0]  ldat_q, ldat_d;
  logic signed [OUT_W-1:0]  rdat_q, rdat_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;

  logic signed [SW-1:0]     cur_s;
  logic [6:0]               cur_v;
  logic [5:0]               gain;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     start_req;

  // Resize an accumulator to the output width. Sign extension and the
  // wrapping truncation both reduce to taking the low OUT_W bits of a
  // sign-extended copy, so the only special case is saturation.
  function automatic logic signed [OUT_W-1:0] fit_out(input logic signed [ACC_W-1:0] a);
    logic signed [WIDE-1:0] w;
    w = WIDE'(a);
`ifdef PAULA_MIX_SAT_EN
    if (OUT_W < ACC_W) begin
      if (w > SAT_MAX)      w = SAT_MAX;
      else if (w < SAT_MIN) w = SAT_MIN;
    end
`endif
    return w[OUT_W-1:0];
  endfunction

  // Shared multiplier: scale the currently indexed shadow channel by its gain.
  // Volume bit 6 forces full gain (63), matching the original Paula.
  always_comb begin
    cur_s    = samp_q[idx_q*SW +: SW];
    cur_v    = vol_q[idx_q*7 +: 7];
    gain     = cur_v[6] ? 6'd63 : cur_v[5:0];
    prod     = PW'(cur_s) * $signed({{(PW-6){1'b0}}, gain});
    prod_ext = ACC_W'(prod);
  end

  assign start_req = mix_stb & clk7_en;

  // Next-state and datapath logic. Defaults hold every register and clear the pulses.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    samp_d  = samp_q;
    vol_d   = vol_q;
    mono_d  = mono_q;
    lacc_d  = lacc_q;
    racc_d  = racc_q;
    ldat_d  = ldat_q;
    rdat_d  = rdat_q;
    valid_d = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          samp_d  = sample;
          vol_d   = vol;
          mono_d  = mono;
          lacc_d  = '0;
          racc_d  = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        ovr_d = start_req;
        if (mono_q || LEFT_MASK[idx_q]) lacc_d = lacc_q + prod_ext;
        if (mono_q || !LEFT_MASK[idx_q]) racc_d = racc_q + prod_ext;
        if (idx_q == IDXW'(NCH - 1)) state_d = DONE;
        else                         idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        ovr_d   = start_req;
        ldat_d  = fit_out(lacc_q);
        rdat_d  = fit_out(racc_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      samp_q  <= '0;
      vol_q   <= '0;
      mono_q  <= 1'b0;
      lacc_q  <= '0;
      racc_q  <= '0;
      ldat_q  <= '0;
      rdat_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      samp_q  <= samp_d;
      vol_q   <= vol_d;
      mono_q  <= mono_d;
      lacc_q  <= lacc_d;
      racc_q  <= racc_d;
      ldat_q  <= ldat_d;
      rdat_q  <= rdat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ldatasum  = ldat_q;
  assign rdatasum  = rdat_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_paula_audio_mixer_mc.sv
// Scoreboard bench for paula_audio_mixer_mc: a default instance (OUT_W=15)
// and an OUT_W=14 instance share all inputs. The stimulus pushes the
// expected pair for each mix, and a monitor pops and compares on out_valid.
module tb_paula_audio_mixer_mc;

  logic        clk, reset, clk7_en, mix_stb, mono;
  logic [31:0] sample;
  logic [27:0] vol;
  logic signed [14:0] ldatasum, rdatasum;
  logic signed [13:0] l14, r14;
  logic out_valid, busy, overrun;
  logic valid14, busy14, ovr14;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int l;
    int r;
    int l14;
    int r14;
  } exp_t;
  exp_t sb_q[$];

  paula_audio_mixer_mc u_dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .mix_stb(mix_stb), .mono(mono),
    .sample(sample), .vol(vol), .ldatasum(ldatasum), .rdatasum(rdatasum),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  paula_audio_mixer_mc #(.OUT_W(14)) u_dut14 (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .mix_stb(mix_stb), .mono(mono),
    .sample(sample), .vol(vol), .ldatasum(l14), .rdatasum(r14),
    .out_valid(valid14), .busy(busy14), .overrun(ovr14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per out_valid and compare both instances.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ldatasum", int'(ldatasum), e.l);
        check("rdatasum", int'(rdatasum), e.r);
        check("valid14", int'(valid14), 1);
        check("ldatasum14", int'(l14), e.l14);
        check("rdatasum14", int'(r14), e.r14);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] s, input logic [6:0] v);
    for (int i = 0; i < 4; i++) begin
      sample[i*8 +: 8] = s;
      vol[i*7 +: 7]    = v;
    end
  endtask

  // Issue one accepted strobe; returns 1 ns after the accept edge.
  task automatic issue(input bit push, input int l, input int r, input int l14e, input int r14e);
    exp_t e;
    mix_stb = 1'b1;
    clk7_en = 1'b1;
    if (push) begin
      e.l = l; e.r = r; e.l14 = l14e; e.r14 = r14e;
      sb_q.push_back(e);
    end
    tick();
    mix_stb = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  int n_busy;
  int sat_l14, wrap_mono14;

  initial begin
`ifdef PAULA_MIX_SAT_EN
    sat_l14     = -8192;
    wrap_mono14 = 8191;
`else
    sat_l14     = 256;
    wrap_mono14 = -3584;
`endif
    reset = 1'b1; clk7_en = 1'b0; mix_stb = 1'b0; mono = 1'b0;
    sample = '0; vol = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_ldatasum", int'(ldatasum), 0);
    check("rst_rdatasum", int'(rdatasum), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    // Test 1: single channel at full gain, latency and busy duration
    sample = '0; vol = '0;
    sample[7:0] = 8'd127;
    vol[6:0]    = 7'h40;
    issue(1, 0, 8001, 0, 8001);
    n_busy = 0;
    while (busy && n_busy < 20) begin
      tick();
      n_busy++;
    end
    check("busy_cycles", n_busy, 5);
    check("latency_out_valid", int'(out_valid), 1);
    tick(); tick();
    check("hold_rdatasum", int'(rdatasum), 8001);

    // Test 2: all channels at negative full scale
    set_all(8'h80, 7'h7F);
    issue(1, -16128, -16128, sat_l14, sat_l14);
    wait_valid();
    tick();

    // Test 3: mono, then stereo
    set_all(8'd100, 7'd32);
    mono = 1'b1;
    issue(1, 12800, 12800, wrap_mono14, wrap_mono14);
    wait_valid();
    tick();
    mono = 1'b0;
    issue(1, 6400, 6400, 6400, 6400);
    wait_valid();
    tick();

    // Test 4: overrun and input changes during RUN do not disturb the mix
    set_all(8'd100, 7'd32);
    mono = 1'b0;
    issue(1, 6400, 6400, 6400, 6400);
    tick();
    set_all(8'h80, 7'h7F);
    mono = 1'b1;
    mix_stb = 1'b1;
    tick();
    mix_stb = 1'b0;
    check("overrun_pulse", int'(overrun), 1);
    tick();
    check("overrun_clear", int'(overrun), 0);
    wait_valid();
    tick();
    mono = 1'b0;

    // Test 5: reset mid-mix aborts with no out_valid
    set_all(8'd50, 7'd10);
    issue(0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_ldatasum", int'(ldatasum), 0);
    check("abort_rdatasum", int'(rdatasum), 0);
    for (int i = 0; i < 7; i++) begin
      check("abort_no_valid", int'(out_valid), 0);
      tick();
    end

    // Test 6: mix after abort completes normally (2*50*10 per side)
    issue(1, 1000, 1000, 1000, 1000);
    wait_valid();
    tick(); tick();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paula_audio_mixer_mc.md
Name: paula_audio_mixer_mc

Overview:
- Parametrised, time-multiplexed successor to the fixed 4-channel Paula stereo mixer.
- Holds NCH channels, each with a signed sample and a 7-bit Paula volume. Channels are routed to left/right by a pan mask parameter, or to both in runtime mono mode.
- Scales and accumulates one channel per clk cycle through a single shared multiplier, then delivers a registered stereo pair with a valid strobe.
- Sits between the Paula audio channel units and the audio output/filter stage.

Parameters:
NCH, 4, number of channels (2..16)
SW, 8, sample width (signed two's complement)
OUT_W, 15, width of ldatasum/rdatasum (signed)
LEFT_MASK, 4'b0110, bit i=1 routes channel i to left, 0 routes to right (NCH bits wide)

Ports:
clk  in  1  bus clock (28 MHz)
reset  in  1  synchronous, active-high reset
clk7_en  in  1  7 MHz clock enable; qualifies mix_stb
mix_stb  in  1  start request; accepted only when clk7_en=1 and idle
mono  in  1  1 = every channel feeds both outputs; sampled at accept
sample  in  NCH*SW  channel i at [i*SW +: SW], signed
vol  in  NCH*7  channel i at [i*7 +: 7], Paula volume
ldatasum  out  OUT_W  left mix, signed, registered
rdatasum  out  OUT_W  right mix, signed, registered
out_valid  out  1  one-cycle pulse when new ldatasum/rdatasum are presented
busy  out  1  high while state != IDLE
overrun  out  1  one-cycle pulse when mix_stb is ignored because the block is busy

Behaviour:
- Reset, synchronous and active-high, one clock: state=IDLE; ldatasum=0, rdatasum=0; out_valid=0, busy=0, overrun=0; accumulators and index cleared. Reset mid-operation aborts the mix with no out_valid and outputs at 0.
- Gain per channel: g = vol[6] ? 63 : vol[5:0], unsigned 0..63. Product p = sample * g, signed, SW+7 bits.
- Accumulator width ACC_W = SW+7+clog2(NCH); no internal overflow is possible.
- State IDLE:
  - On mix_stb & clk7_en: latch sample, vol and mono into shadow registers (later input changes do not affect this mix); clear both accumulators; idx=0; go to RUN.
- State RUN, one channel per clk, not gated by clk7_en:
  - If mono=1, add p(idx) to both accumulators.
  - Otherwise add p(idx) to the left accumulator if LEFT_MASK[idx]=1, else to the right.
  - If idx==NCH-1, go to DONE; otherwise idx++.
- State DONE:
  - Load ldatasum/rdatasum from the accumulators (width rule below).
  - Assert out_valid for exactly that one cycle; go to IDLE.
- Latency: with accept at edge E0, outputs update and out_valid is high after edge E(NCH+1). Default is 5 clk. A new accept is possible in the out_valid cycle; out_valid and a new accept may coincide.
- Outputs hold their value between mixes.
- Busy collision: mix_stb & clk7_en while state != IDLE is ignored, shadow registers are unchanged, and overrun pulses for one cycle.
- Width rule, ACC_W to OUT_W:
  - If OUT_W >= ACC_W, sign-extend.
  - If OUT_W < ACC_W, handling is per the Optional Feature.
- Empty side: a side with no routed channels outputs 0.

Optional Feature:
- Macro: PAULA_MIX_SAT_EN.
- Defined: when OUT_W < ACC_W, each output saturates to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: when OUT_W < ACC_W, each output is the low OUT_W bits of its accumulator (wraps).
- With OUT_W >= ACC_W, behaviour is identical either way.

Test Plan:
- Defaults; sample0=127, vol0=7'h40, other vols 0; pulse mix_stb with clk7_en -> out_valid exactly 5 clk after accept; rdatasum=8001 (g=63); ldatasum=0; busy high 5 cycles.
- Defaults; all samples=-128, all vol=7'h7F -> ldatasum=rdatasum=-16128 (15'h4100).
- OUT_W=14, same stimulus as previous -> with PAULA_MIX_SAT_EN outputs=-8192 (14'h2000); without it outputs=14'h0100.
- Defaults; mono=1; all samples=100, vol=32 -> ldatasum=rdatasum=12800. Then mono=0, same inputs -> each output=6400.
- Accept a mix; second mix_stb&clk7_en 2 clk later -> overrun one-cycle pulse; result equals the first mix. Change sample inputs during RUN -> result unaffected.
- Assert reset 2 clk after accept -> busy=0 next cycle, no out_valid, outputs=0. A subsequent mix completes normally.
